// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel width, minimum frame dimension and FSM state type
// for the Sobel frame controller.
package sobel_pkg;
    localparam int unsigned PIXEL_W = 8;
    localparam int unsigned MIN_DIM = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;
endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if: valid/ready pixel stream; master drives data, slave drives ready.
interface sobel_frame_ctrl_if;
    import sobel_pkg::*;

    logic               valid;
    logic               ready;
    logic               last;
    logic [PIXEL_W-1:0] pixel;

    modport master (output valid, pixel, last, input ready);
    modport slave  (input valid, pixel, output ready);
endinterface

// File: rtl/sobel_out_fifo.sv
// sobel_out_fifo: synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module sobel_out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: sequences one frame through an external Sobel core and buffers its output.
// Defining SOBEL_CTRL_PERF_EN adds perf_cycles/perf_stalls counters.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned MAX_WIDTH  = 4096,
    parameter int unsigned MAX_HEIGHT = 4096,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_WIDTH)-1:0]  cfg_width,
    input  logic [$clog2(MAX_HEIGHT)-1:0] cfg_height,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    sobel_frame_ctrl_if.slave             s_if,
    sobel_frame_ctrl_if.master            m_if,
    output logic                          core_rst,
    output logic                          core_valid_in,
    output logic [PIXEL_W-1:0]            core_pixel_in,
    output logic [$clog2(MAX_WIDTH)-1:0]  core_width,
    input  logic                          core_valid_out,
    input  logic [PIXEL_W-1:0]            core_pixel_out
`ifdef SOBEL_CTRL_PERF_EN
    ,
    output logic [31:0]                   perf_cycles,
    output logic [31:0]                   perf_stalls
`endif
);
    localparam int unsigned WW = $clog2(MAX_WIDTH);
    localparam int unsigned HW = $clog2(MAX_HEIGHT);
    localparam int unsigned CW = WW + HW;
    localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

    state_e             state_q, state_d;
    logic [WW-1:0]      width_q, width_d;
    logic [CW-1:0]      in_total_q, in_total_d, out_total_q, out_total_d;
    logic [CW-1:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic               inflight_q, inflight_d;
    logic               done_q, done_d, cfg_err_q, cfg_err_d;
    logic               cfg_ok, s_ready, xfer, push, pop, last_beat, fifo_empty;
    logic [FW-1:0]      fifo_count;
    logic [PIXEL_W-1:0] fifo_dout;

    assign cfg_ok = (cfg_width >= WW'(MIN_DIM)) && (cfg_height >= HW'(MIN_DIM));

    // A pixel still inside the core may emit one result next cycle, so it reserves a slot.
    assign s_ready   = (state_q == ST_RUN) && ((fifo_count + FW'(inflight_q)) < FW'(FIFO_DEPTH));
    assign s_if.ready = s_ready;
    assign xfer      = s_if.valid & s_ready;
    assign push      = core_valid_out & inflight_q;
    assign pop       = m_if.valid & m_if.ready;
    assign last_beat = (out_cnt_q == out_total_q - CW'(1));

    assign m_if.valid = ~fifo_empty;
    assign m_if.pixel = fifo_dout;
    assign m_if.last  = ~fifo_empty & last_beat;

    assign core_rst      = ~rst | (state_q == ST_CLR);
    assign core_valid_in = xfer;
    assign core_pixel_in = s_if.pixel;
    assign core_width    = width_q;

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        in_total_d  = in_total_q;
        out_total_d = out_total_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        inflight_d  = xfer;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        if (xfer) in_cnt_d  = in_cnt_q + CW'(1);
        if (pop)  out_cnt_d = out_cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d     = cfg_width;
                        in_total_d  = CW'(cfg_width) * CW'(cfg_height);
                        out_total_d = CW'(cfg_width - WW'(2)) * CW'(cfg_height - HW'(2));
                        in_cnt_d    = '0;
                        out_cnt_d   = '0;
                        state_d     = ST_CLR;
                    end else begin
                        done_d    = 1'b1;
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_CLR:   state_d = ST_RUN;
            ST_RUN: begin
                if (xfer && (in_cnt_q == in_total_q - CW'(1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && last_beat) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            in_total_q  <= '0;
            out_total_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            in_total_q  <= in_total_d;
            out_total_q <= out_total_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    sobel_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIXEL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (core_pixel_out),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (state_q == ST_IDLE) begin
            if (start && cfg_ok) begin
                perf_cycles_d = '0;
                perf_stalls_d = '0;
            end
        end else begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
        if ((state_q == ST_RUN) && s_if.valid && !s_ready) perf_stalls_d = perf_stalls_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: table-driven and randomized frames through the controller with a
// behavioural Sobel core attached; outputs checked against a whole-frame golden model.
module tb_sobel_frame_ctrl;
    import sobel_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int IMG_N    = 256;
    localparam int PAT_RAMP = 0;
    localparam int PAT_STEP = 1;
    localparam int PAT_RAND = 2;

    typedef logic [7:0] img_t [IMG_N];

    typedef struct {
        int w;
        int h;
        int pat;
        int rmode;
        int svmode;
        int exp_out;
        bit exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] cfg_width, cfg_height;
    logic        busy, done, cfg_err;
    logic        core_rst, core_valid_in;
    logic [7:0]  core_pixel_in;
    logic [11:0] core_width;
    logic        core_valid_out;
    logic [7:0]  core_pixel_out;
`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    int n_cmp, n_bad;
    int sent_m, cyc_m, n_done;
    vec_t vecs [8];

    sobel_frame_ctrl_if s_bus ();
    sobel_frame_ctrl_if m_bus ();

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .MAX_WIDTH  (4096),
        .MAX_HEIGHT (4096),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .s_if           (s_bus),
        .m_if           (m_bus),
        .core_rst       (core_rst),
        .core_valid_in  (core_valid_in),
        .core_pixel_in  (core_pixel_in),
        .core_width     (core_width),
        .core_valid_out (core_valid_out),
        .core_pixel_out (core_pixel_out)
`ifdef SOBEL_CTRL_PERF_EN
        ,
        .perf_cycles    (perf_cycles),
        .perf_stalls    (perf_stalls)
`endif
    );

    // 3x3 Sobel gradient |Gx|+|Gy| saturated to 255, centred at (r,c) of a row-major frame.
    function automatic int sobel_at(input img_t im, input int w, input int r, input int c);
        int a [3][3];
        int gx, gy, m;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = int'(im[(r - 1 + i) * w + (c - 1 + j)]);
        gx = a[0][2] + 2 * a[1][2] + a[2][2] - a[0][0] - 2 * a[1][0] - a[2][0];
        gy = a[2][0] + 2 * a[2][1] + a[2][2] - a[0][0] - 2 * a[0][1] - a[0][2];
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // Behavioural core: one-cycle latency, valid_out only updates on valid_in and is held otherwise.
    img_t core_mem;
    int   core_idx;
    always @(posedge clk) begin : core_model
        int cw, cr, cc;
        if (core_rst) begin
            core_idx       <= 0;
            core_valid_out <= 1'b0;
            core_pixel_out <= 8'h00;
        end else if (core_valid_in) begin
            cw = (core_width == 12'd0) ? 1 : int'(core_width);
            if (core_idx < IMG_N) core_mem[core_idx] = core_pixel_in;
            cr = core_idx / cw;
            cc = core_idx % cw;
            core_idx <= core_idx + 1;
            if (cr >= 2 && cc >= 2 && core_idx < IMG_N) begin
                core_valid_out <= 1'b1;
                core_pixel_out <= 8'(sobel_at(core_mem, cw, cr - 1, cc - 1));
            end else begin
                core_valid_out <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},          32'(busy),          0);
        check({tag, "_done"},          32'(done),          0);
        check({tag, "_cfg_err"},       32'(cfg_err),       0);
        check({tag, "_s_ready"},       32'(s_bus.ready),   0);
        check({tag, "_m_valid"},       32'(m_bus.valid),   0);
        check({tag, "_m_last"},        32'(m_bus.last),    0);
        check({tag, "_core_valid_in"}, 32'(core_valid_in), 0);
        check({tag, "_core_rst"},      32'(core_rst),      1);
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int pat,
                             input int rmode, input int svmode, input bit midstart,
                             input int exp_out, input bit exp_err);
        img_t ref_img;
        int   exp_q [$];
        int   total, sent, n_out, cyc, last_hs, crst_n, crst_first, fifo_max, bad_w, extra_in, budget, e;
        bit   got_done;
        total = w * h;
        for (int i = 0; i < total && i < IMG_N; i++) begin
            case (pat)
                PAT_RAMP: ref_img[i] = 8'((i * 9) & 255);
                PAT_STEP: ref_img[i] = ((i % w) >= (w / 2)) ? 8'd255 : 8'd0;
                default:  ref_img[i] = 8'($urandom_range(0, 255));
            endcase
        end
        if (!exp_err)
            for (int r = 1; r <= h - 2; r++)
                for (int c = 1; c <= w - 2; c++)
                    exp_q.push_back(sobel_at(ref_img, w, r, c));
        sent = 0; n_out = 0; cyc = 0; last_hs = -100; crst_n = 0; crst_first = -1;
        fifo_max = 0; bad_w = 0; extra_in = 0; got_done = 1'b0;
        budget = 40 * total + 100;

        @(negedge clk);
        start = 1'b1; cfg_width = 12'(w); cfg_height = 12'(h);
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < budget) begin
            if (sent < total) begin
                if (svmode == 0 || $urandom_range(0, 3) != 0) begin
                    s_bus.valid = 1'b1; s_bus.pixel = ref_img[sent];
                end else begin
                    s_bus.valid = 1'b0; s_bus.pixel = 8'($urandom);
                end
            end else begin
                s_bus.valid = (svmode == 0); s_bus.pixel = 8'hA5;
            end
            case (rmode)
                0:       m_bus.ready = 1'b1;
                1:       m_bus.ready = (cyc % 3 == 0);
                default: m_bus.ready = 1'($urandom_range(0, 1));
            endcase
            if (midstart && cyc == 6) begin
                start = 1'b1; cfg_width = 12'd3; cfg_height = 12'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (core_rst) begin
                if (crst_n == 0) crst_first = cyc;
                crst_n++;
            end
            if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
            if (busy && core_width != 12'(w)) bad_w++;
            if (s_bus.valid && s_bus.ready) begin
                if (sent < total) sent++;
                else extra_in++;
            end
            if (m_bus.valid && m_bus.ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_out"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_pix"},  32'(m_bus.pixel), 32'(e));
                    check({tag, "_last"}, 32'(m_bus.last),  32'(exp_q.size() == 0));
                end
                n_out++;
                last_hs = cyc;
            end
            if (done) begin
                got_done = 1'b1;
                check({tag, "_cfg_err"}, 32'(cfg_err), 32'(exp_err));
                check({tag, "_busy_at_done"}, 32'(busy), 0);
                if (exp_err) check({tag, "_reject_latency"}, 32'(cyc), 0);
                else         check({tag, "_done_latency"}, 32'(cyc - last_hs), 1);
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        s_bus.valid = 1'b0;
        check({tag, "_done_seen"}, 32'(got_done), 1);
        @(negedge clk);
        #1;
        check({tag, "_done_width"}, 32'(done), 0);
        check({tag, "_count"},      32'(n_out), 32'(exp_out));
        check({tag, "_pending"},    32'(exp_q.size()), 0);
        check({tag, "_fifo_bound"}, 32'(fifo_max <= int'(FIFO_DEPTH)), 1);
        check({tag, "_core_width"}, 32'(bad_w), 0);
        check({tag, "_extra_in"},   32'(extra_in), 0);
        check({tag, "_core_rst_cycles"}, 32'(crst_n), exp_err ? 0 : 1);
        if (!exp_err) check({tag, "_core_rst_at"}, 32'(crst_first), 0);
    endtask

    initial begin
        int w, h;
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
        s_bus.valid = 1'b0; s_bus.pixel = '0; s_bus.last = 1'b0; m_bus.ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst = 1'b1;

        //          w   h   pattern   rmode svmode out err
        vecs[0] = '{4,  4,  PAT_RAMP, 0,    0,     4,  1'b0};
        vecs[1] = '{5,  3,  PAT_STEP, 0,    0,     3,  1'b0};
        vecs[2] = '{16, 8,  PAT_RAND, 1,    0,     84, 1'b0};
        vecs[3] = '{2,  10, PAT_RAND, 0,    0,     0,  1'b1};
        vecs[4] = '{3,  3,  PAT_RAND, 2,    1,     1,  1'b0};
        vecs[5] = '{7,  5,  PAT_STEP, 2,    1,     15, 1'b0};
        vecs[6] = '{10, 2,  PAT_RAMP, 0,    0,     0,  1'b1};
        vecs[7] = '{3,  12, PAT_RAND, 1,    1,     10, 1'b0};
        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].w, vecs[i].h, vecs[i].pat, vecs[i].rmode,
                      vecs[i].svmode, 1'b0, vecs[i].exp_out, vecs[i].exp_err);

        run_frame("busy_start", 6, 5, PAT_RAND, 2, 1, 1'b1, 12, 1'b0);

        run_frame("b2b_a", 4, 4, PAT_RAND, 0, 0, 1'b0, 4, 1'b0);
        run_frame("b2b_b", 4, 4, PAT_RAND, 0, 0, 1'b0, 4, 1'b0);

        // Abort an 8x8 frame after 20 inputs, then a fresh 4x4 must see no leftovers.
        @(negedge clk);
        start = 1'b1; cfg_width = 12'd8; cfg_height = 12'd8;
        @(negedge clk);
        start = 1'b0;
        sent_m = 0; cyc_m = 0; n_done = 0;
        m_bus.ready = 1'b1;
        while (sent_m < 20 && cyc_m < 400) begin
            s_bus.valid = 1'b1; s_bus.pixel = 8'($urandom);
            #1;
            if (done) n_done++;
            if (s_bus.valid && s_bus.ready) sent_m++;
            @(negedge clk);
            cyc_m++;
        end
        check("rstmid_inputs", 32'(sent_m), 20);
        rst = 1'b0; s_bus.valid = 1'b0;
        #1;
        check_reset("rstmid");
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) n_done++;
        end
        check("rstmid_no_done", 32'(n_done), 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame("after_rst", 4, 4, PAT_RAMP, 0, 0, 1'b0, 4, 1'b0);

        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(3, 10);
            h = $urandom_range(3, 10);
            run_frame($sformatf("rand%0d", k), w, h, PAT_RAND, 2, 1, 1'b0, (w - 2) * (h - 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
